// File: rtl/vtim_rx.sv
// ---------------------------------------------------------------------------
// vtim_rx -- video timing receiver / measurer
//
// Watches a blanking/sync stream qualified by ce_pix and:
//   * regenerates de, hpos and vpos for the active area,
//   * measures pixels per line, lines per frame and the active area size,
//   * publishes the measurements once per frame with a one-cycle frame_stb,
//   * declares lock after LOCK_FRAMES consecutive identical frames, and
//     drops back to searching when no vertical sync arrives for
//     2^TMO_BITS-1 pixel enables.
//
// Ports
//   mclk       in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset (release synchronised)
//   ce_pix     in   pixel enable; inputs sampled only when 1
//   hblk/vblk  in   blanking, active-high
//   hsyn/vsyn  in   sync, active-low
//   hpos/vpos  out  position inside the active area (9 bit)
//   de         out  registered ~(hblk|vblk)
//   htotal     out  pixel enables per line (reference line of the frame)
//   vtotal     out  lines per frame
//   hact/vact  out  active pixels per line / active lines per frame
//   hmis       out  the last closed frame had lines of unequal length
//   frame_stb  out  one-cycle pulse when the measurements above update
//   locked     out  stable timing detected
// ---------------------------------------------------------------------------
module vtim_rx #(
    parameter int LOCK_FRAMES = 2,
    parameter int TMO_BITS    = 20
) (
    input  logic       mclk,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       hblk,
    input  logic       vblk,
    input  logic       hsyn,
    input  logic       vsyn,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       de,
    output logic [9:0] htotal,
    output logic [9:0] vtotal,
    output logic [8:0] hact,
    output logic [8:0] vact,
    output logic       hmis,
    output logic       frame_stb,
    output logic       locked
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCK} state_t;

    localparam logic [7:0]          LOCK_N   = LOCK_FRAMES[7:0];
    localparam logic [TMO_BITS-1:0] TMO_FULL = '1;
    localparam logic [TMO_BITS-1:0] TMO_LAST = {{(TMO_BITS-1){1'b1}}, 1'b0};

    function automatic logic [9:0] inc10(input logic [9:0] x);
        return (x == 10'h3FF) ? x : x + 10'd1;
    endfunction

    function automatic logic [8:0] inc9(input logic [8:0] x);
        return (x == 9'h1FF) ? x : x + 9'd1;
    endfunction

    // Reset asserts immediately, releases two clocks after reset_n rises.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) rst_sync_reg <= 2'b00;
        else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_int_n = rst_sync_reg[1];

    // Previous-sample registers and measurement state
    logic                hsyn_q_reg, vsyn_q_reg, hblk_q_reg, vblk_q_reg;
    logic [9:0]          lcnt_reg, ref_len_reg, fcnt_reg;
    logic                ref_valid_reg, mis_reg;
    logic [8:0]          pcnt_reg, hact_line_reg, acnt_reg, vact_cap_reg;
    logic                acnt_first_reg, de_reg;
    logic [TMO_BITS-1:0] tmo_reg;

    // Published / control state
    state_t     state_reg;
    logic [7:0] match_reg;
    logic       first_close_reg;
    logic [9:0] htotal_reg, vtotal_reg;
    logic [8:0] hact_reg, vact_reg;
    logic       hmis_reg, frame_stb_reg, locked_reg;

    // Edges between consecutive ce_pix samples
    logic hs_fall, vs_fall, hb_fall, hb_rise, vb_fall, vb_rise;
    assign hs_fall = ce_pix &  hsyn_q_reg & ~hsyn;
    assign vs_fall = ce_pix &  vsyn_q_reg & ~vsyn;
    assign hb_fall = ce_pix &  hblk_q_reg & ~hblk;
    assign hb_rise = ce_pix & ~hblk_q_reg &  hblk;
    assign vb_fall = ce_pix &  vblk_q_reg & ~vblk;
    assign vb_rise = ce_pix & ~vblk_q_reg &  vblk;

    // Line finishing on this sample is folded in before a coincident
    // frame close, so the close sees that line's length and count.
    logic [9:0] len_now, ref_now, ftot_now;
    logic       line_mis, mis_now, tuple_eq, is_match, tmo_hit;

    assign len_now  = inc10(lcnt_reg);
    assign line_mis = hs_fall & ref_valid_reg & (len_now != ref_len_reg);
    assign mis_now  = mis_reg | line_mis;
    assign ref_now  = (hs_fall & ~ref_valid_reg) ? len_now : ref_len_reg;
    assign ftot_now = hs_fall ? inc10(fcnt_reg) : fcnt_reg;
    assign tuple_eq = (ref_now == htotal_reg) && (ftot_now == vtotal_reg) &&
                      (hact_line_reg == hact_reg) && (vact_cap_reg == vact_reg);
    assign is_match = tuple_eq & ~mis_now & ~first_close_reg;
    // Fires on the sample that brings the timeout counter to all-ones.
    assign tmo_hit  = ce_pix & ~vs_fall & (tmo_reg == TMO_LAST);

    always_ff @(posedge mclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            hsyn_q_reg     <= 1'b1;
            vsyn_q_reg     <= 1'b1;
            hblk_q_reg     <= 1'b1;
            vblk_q_reg     <= 1'b1;
            lcnt_reg       <= '0;
            ref_len_reg    <= '0;
            ref_valid_reg  <= 1'b0;
            mis_reg        <= 1'b0;
            fcnt_reg       <= '0;
            pcnt_reg       <= '0;
            hact_line_reg  <= '0;
            acnt_reg       <= '0;
            acnt_first_reg <= 1'b0;
            vact_cap_reg   <= '0;
            tmo_reg        <= '0;
            de_reg         <= 1'b0;
        end else if (ce_pix) begin
            hsyn_q_reg <= hsyn;
            vsyn_q_reg <= vsyn;
            hblk_q_reg <= hblk;
            vblk_q_reg <= vblk;
            de_reg     <= ~(hblk | vblk);

            lcnt_reg <= hs_fall ? 10'd0 : inc10(lcnt_reg);

            // Reference line is the first full line after a frame close.
            if (vs_fall) begin
                ref_valid_reg <= 1'b0;
                ref_len_reg   <= '0;
                mis_reg       <= 1'b0;
            end else if (hs_fall) begin
                if (!ref_valid_reg) begin
                    ref_len_reg   <= len_now;
                    ref_valid_reg <= 1'b1;
                end else if (line_mis) begin
                    mis_reg <= 1'b1;
                end
            end

            if (vs_fall)      fcnt_reg <= '0;
            else if (hs_fall) fcnt_reg <= inc10(fcnt_reg);

            if (hb_fall)    pcnt_reg <= '0;
            else if (!hblk) pcnt_reg <= inc9(pcnt_reg);
            if (hb_rise)    hact_line_reg <= inc9(pcnt_reg);

            // The first active line starts at 0; later lines count up.
            if (vb_fall) begin
                acnt_reg       <= '0;
                acnt_first_reg <= ~hb_fall;
            end else if (hb_fall && !vblk) begin
                if (acnt_first_reg) acnt_first_reg <= 1'b0;
                else                acnt_reg       <= inc9(acnt_reg);
            end
            if (vb_rise) vact_cap_reg <= inc9(acnt_reg);

            if (vs_fall)                tmo_reg <= '0;
            else if (tmo_reg != TMO_FULL) tmo_reg <= tmo_reg + 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_reg       <= SEARCH;
            match_reg       <= '0;
            first_close_reg <= 1'b0;
            htotal_reg      <= '0;
            vtotal_reg      <= '0;
            hact_reg        <= '0;
            vact_reg        <= '0;
            hmis_reg        <= 1'b0;
            frame_stb_reg   <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            frame_stb_reg <= 1'b0;
            if (tmo_hit) begin
                // Loss of signal: published values are deliberately held.
                state_reg  <= SEARCH;
                match_reg  <= '0;
                locked_reg <= 1'b0;
            end else if (vs_fall) begin
                if (state_reg == SEARCH) begin
                    state_reg       <= TRACK;
                    match_reg       <= '0;
                    first_close_reg <= 1'b1;
                end else begin
                    htotal_reg      <= ref_now;
                    vtotal_reg      <= ftot_now;
                    hact_reg        <= hact_line_reg;
                    vact_reg        <= vact_cap_reg;
                    hmis_reg        <= mis_now;
                    frame_stb_reg   <= 1'b1;
                    first_close_reg <= 1'b0;
                    if (state_reg == TRACK) begin
                        if (!is_match) begin
                            match_reg <= '0;
                        end else if (match_reg + 8'd1 == LOCK_N) begin
                            state_reg  <= LOCK;
                            match_reg  <= '0;
                            locked_reg <= 1'b1;
                        end else begin
                            match_reg <= match_reg + 8'd1;
                        end
                    end else if (!is_match) begin
                        state_reg  <= TRACK;
                        match_reg  <= '0;
                        locked_reg <= 1'b0;
                    end
                end
            end
        end
    end

    assign hpos      = pcnt_reg;
    assign vpos      = acnt_reg;
    assign de        = de_reg;
    assign htotal    = htotal_reg;
    assign vtotal    = vtotal_reg;
    assign hact      = hact_reg;
    assign vact      = vact_reg;
    assign hmis      = hmis_reg;
    assign frame_stb = frame_stb_reg;
    assign locked    = locked_reg;

endmodule

// File: tb/tb_vtim_rx.sv
// ---------------------------------------------------------------------------
// tb_vtim_rx -- directed bench for vtim_rx on a reduced raster
// (48 CE/line, hsync 4, active 32 from pixel 8; 20 lines, vsync 2,
// active 16 from line 3) with an 11-bit timeout so the whole run stays short.
// ---------------------------------------------------------------------------
module tb_vtim_rx;

    localparam int HT = 48, HS = 4, HB0 = 8, HA = 32;
    localparam int VT = 20, VS = 2, VB0 = 3, VA = 16;
    localparam int TMO = 11;
    localparam int FRAME = HT * VT;
    localparam int TMO_MAX = (1 << TMO) - 1;

    logic       mclk = 1'b0, reset_n = 1'b0, ce_pix = 1'b0;
    logic       hblk = 1'b1, vblk = 1'b1, hsyn = 1'b1, vsyn = 1'b1;
    logic [8:0] hpos, vpos, hact, vact;
    logic [9:0] htotal, vtotal;
    logic       de, hmis, frame_stb, locked;

    vtim_rx #(.LOCK_FRAMES(2), .TMO_BITS(TMO)) dut (
        .mclk(mclk), .reset_n(reset_n), .ce_pix(ce_pix),
        .hblk(hblk), .vblk(vblk), .hsyn(hsyn), .vsyn(vsyn),
        .hpos(hpos), .vpos(vpos), .de(de),
        .htotal(htotal), .vtotal(vtotal), .hact(hact), .vact(vact),
        .hmis(hmis), .frame_stb(frame_stb), .locked(locked)
    );

    always #5 mclk = ~mclk;

    int  n_tests = 0, n_fail = 0;
    int  hp = 0, vp = 0, long_v = -1;
    bit  vs_en = 1'b1, gap_mode = 1'b0;
    int  stb_seen = 0, stb_exp = 0;

    // Outputs captured just after each sampling edge
    logic       snap_stb, snap_locked, snap_hmis, snap_de;
    logic [9:0] snap_ht, snap_vt;
    logic [8:0] snap_ha, snap_va, snap_hp, snap_vp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel sample at raster position (hp, vp), then advance the raster.
    task automatic emit();
        int len;
        hsyn  = !(hp < HS);
        vsyn  = !(vs_en && vp < VS);
        hblk  = !(hp >= HB0 && hp < HB0 + HA);
        vblk  = !(vp >= VB0 && vp < VB0 + VA);
        ce_pix = 1'b1;
        @(posedge mclk); #1;
        ce_pix = 1'b0;
        snap_stb = frame_stb; snap_locked = locked; snap_hmis = hmis; snap_de = de;
        snap_ht = htotal; snap_vt = vtotal; snap_ha = hact; snap_va = vact;
        snap_hp = hpos; snap_vp = vpos;
        if (frame_stb) stb_seen++;
        if (gap_mode) begin
            repeat ($urandom_range(2, 4)) begin
                @(posedge mclk); #1;
                if (frame_stb) stb_seen++;
            end
        end
        len = HT + ((vp == long_v) ? 1 : 0);
        hp++;
        if (hp >= len) begin
            hp = 0;
            vp++;
            if (vp == VT) begin
                vp = 0;
                long_v = -1;
            end
        end
    endtask

    task automatic check_close(input string ph, input bit exp_stb, input bit exp_lock, input bit exp_hmis);
        stb_exp += int'(exp_stb);
        check_val({ph, " stb"}, snap_stb, exp_stb);
        check_val({ph, " locked"}, snap_locked, exp_lock);
        if (exp_stb) begin
            check_val({ph, " htotal"}, snap_ht, HT);
            check_val({ph, " vtotal"}, snap_vt, VT);
            check_val({ph, " hact"}, snap_ha, HA);
            check_val({ph, " vact"}, snap_va, VA);
            check_val({ph, " hmis"}, snap_hmis, exp_hmis);
        end
    endtask

    // Whole frame starting at its vsync fall; the close is checked first.
    task automatic frame(input string ph, input bit exp_stb, input bit exp_lock,
                         input bit exp_hmis, input bit pos_chk);
        int eh, ev;
        emit();
        check_close(ph, exp_stb, exp_lock, exp_hmis);
        do begin
            eh = hp; ev = vp;
            emit();
            if (pos_chk) begin
                if (ev == VB0 && eh == HB0) begin
                    check_val({ph, " first de"}, snap_de, 1);
                    check_val({ph, " first hpos"}, snap_hp, 0);
                    check_val({ph, " first vpos"}, snap_vp, 0);
                end
                if (ev == VB0 + VA - 1 && eh == HB0 + HA - 1) begin
                    check_val({ph, " last de"}, snap_de, 1);
                    check_val({ph, " last hpos"}, snap_hp, HA - 1);
                    check_val({ph, " last vpos"}, snap_vp, VA - 1);
                end
                if (ev == VB0 + VA - 1 && eh == HB0 + HA)
                    check_val({ph, " after de"}, snap_de, 0);
            end
        end while (!(hp == 0 && vp == 0));
    endtask

    task automatic check_zero(input string ph);
        check_val({ph, " locked"}, locked, 0);
        check_val({ph, " stb"}, frame_stb, 0);
        check_val({ph, " htotal"}, htotal, 0);
        check_val({ph, " vtotal"}, vtotal, 0);
        check_val({ph, " hact"}, hact, 0);
        check_val({ph, " vact"}, vact, 0);
        check_val({ph, " hmis"}, hmis, 0);
        check_val({ph, " de"}, de, 0);
        check_val({ph, " hpos"}, hpos, 0);
        check_val({ph, " vpos"}, vpos, 0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge mclk);
        #1;
        check_zero("rst");
        reset_n = 1'b1;
        repeat (3) @(posedge mclk);
        #1;

        // Acquire, lock at the 4th fall, then one long line breaks lock
        frame("p1 f1", 0, 0, 0, 0);
        frame("p1 f2", 1, 0, 0, 1);
        frame("p1 f3", 1, 0, 0, 0);
        frame("p1 f4", 1, 1, 0, 0);
        long_v = 5;
        frame("p1 f5", 1, 1, 0, 0);
        frame("p1 f6", 1, 0, 1, 0);
        frame("p1 f7", 1, 0, 0, 0);
        frame("p1 f8", 1, 1, 0, 0);

        // Vsync held high: lock lost exactly at 2^TMO-1 samples after the fall
        vs_en = 1'b0;
        repeat (TMO_MAX - 1 - (FRAME - 1)) emit();
        check_val("tmo before", snap_locked, 1);
        emit();
        check_val("tmo locked", snap_locked, 0);
        check_val("tmo htotal held", snap_ht, HT);
        vs_en = 1'b1;
        while (!(hp == 0 && vp == 0)) emit();
        frame("to f1", 0, 0, 0, 0);
        frame("to f2", 1, 0, 0, 0);
        frame("to f3", 1, 0, 0, 0);
        frame("to f4", 1, 1, 0, 0);

        // Reset pulsed in the middle of an active line
        emit();
        check_close("mid close", 1, 1, 0);
        repeat (FRAME / 2 + 19) emit();
        check_val("mid de before", snap_de, 1);
        reset_n = 1'b0;
        #1;
        check_zero("mid rst");
        repeat (2) @(posedge mclk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        while (!(hp == 0 && vp == 0)) emit();
        frame("rs f1", 0, 0, 0, 0);
        frame("rs f2", 1, 0, 0, 0);
        frame("rs f3", 1, 0, 0, 0);
        frame("rs f4", 1, 1, 0, 0);

        // Sparse pixel enables with random gaps
        reset_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        gap_mode = 1'b1;
        frame("ce f1", 0, 0, 0, 0);
        frame("ce f2", 1, 0, 0, 1);
        frame("ce f3", 1, 0, 0, 0);
        frame("ce f4", 1, 1, 0, 0);

        check_val("stb pulses", stb_seen, stb_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
